// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: request-vector bit indices
// and register-map offsets relative to IO_BASE.
package interrupt_controller_pkg;

  localparam int INT_IDX_CT  = 1;
  localparam int INT_IDX_SW  = 2;
  localparam int INT_IDX_K1  = 3;
  localparam int INT_IDX_K0  = 4;
  localparam int INT_IDX_SIO = 5;
  localparam int INT_IDX_PT  = 6;

  localparam logic [11:0] OFF_IT    = 12'h000;
  localparam logic [11:0] OFF_ISW   = 12'h001;
  localparam logic [11:0] OFF_IPT   = 12'h002;
  localparam logic [11:0] OFF_ISIO  = 12'h003;
  localparam logic [11:0] OFF_IK0   = 12'h004;
  localparam logic [11:0] OFF_IK1   = 12'h005;
  localparam logic [11:0] OFF_EIT   = 12'h010;
  localparam logic [11:0] OFF_EISW  = 12'h011;
  localparam logic [11:0] OFF_EIPT  = 12'h012;
  localparam logic [11:0] OFF_EISIO = 12'h013;
  localparam logic [11:0] OFF_EIK0  = 12'h014;
  localparam logic [11:0] OFF_EIK1  = 12'h015;
  localparam logic [11:0] OFF_KCP0  = 12'h016;

endpackage

// File: rtl/interrupt_k_port_detect.sv
// Input-port change detector: 2-flop synchronizer, clk_en-held previous sample,
// and per-pin enable/compare qualification into a single event.
module interrupt_k_port_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en_i,
  input  logic [WIDTH-1:0] pins_i,
  input  logic [WIDTH-1:0] enable_i,
  input  logic [WIDTH-1:0] compare_i,
  output logic             event_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

  // Pins idle high, so everything resets to ones to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
      if (clk_en_i) prev_q <= sync2_q;
    end
  end

  assign event_o = |(enable_i & (sync2_q ^ prev_q) & (sync2_q ^ compare_i));

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt requester: factor flags (reset-on-read), mask registers and the
// registered 15-bit request vector scanned by the microcode sequencer.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [11:0] IO_BASE = 12'hF00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [3:0]  clock_timer_event,
  input  logic [1:0]  stopwatch_event,
  input  logic        prog_timer_event,
  input  logic        serial_event,
  input  logic [3:0]  k0_in,
  input  logic        k1_in,
  input  logic [11:0] bus_addr,
  input  logic        bus_read_en,
  input  logic        bus_write_en,
  input  logic [3:0]  bus_data_in,
  output logic [3:0]  bus_data_out,
  output logic        bus_addr_hit,
  output logic [14:0] interrupt_req
);

  logic [3:0]  it_q, it_d, eit_q, eit_d, eik0_q, eik0_d, kcp0_q, kcp0_d;
  logic [1:0]  isw_q, isw_d, eisw_q, eisw_d;
  logic        ipt_q, ipt_d, isio_q, isio_d, ik0_q, ik0_d, ik1_q, ik1_d;
  logic        eipt_q, eipt_d, eisio_q, eisio_d, eik1_q, eik1_d;
  logic [14:0] irq_q, irq_d;
  logic [11:0] off;
  logic [3:0]  rdata;
  logic        hit, rd_fire, wr_fire, k0_event, k1_event;

  assign off = bus_addr - IO_BASE;

  always_comb begin
    hit   = 1'b1;
    rdata = '0;
    case (off)
      OFF_IT:    rdata = it_q;
      OFF_ISW:   rdata = {2'b00, isw_q};
      OFF_IPT:   rdata = {3'b000, ipt_q};
      OFF_ISIO:  rdata = {3'b000, isio_q};
      OFF_IK0:   rdata = {3'b000, ik0_q};
      OFF_IK1:   rdata = {3'b000, ik1_q};
      OFF_EIT:   rdata = eit_q;
      OFF_EISW:  rdata = {2'b00, eisw_q};
      OFF_EIPT:  rdata = {3'b000, eipt_q};
      OFF_EISIO: rdata = {3'b000, eisio_q};
      OFF_EIK0:  rdata = eik0_q;
      OFF_EIK1:  rdata = {3'b000, eik1_q};
      OFF_KCP0:  rdata = kcp0_q;
      default:   hit   = 1'b0;
    endcase
  end

  assign bus_addr_hit  = hit;
  assign bus_data_out  = rdata;
  assign interrupt_req = irq_q;

  // Bus strobes are single-cycle qualifiers: a read or write acts only on a clk_en edge with an address hit.
  assign rd_fire = clk_en & bus_read_en & hit;
  assign wr_fire = clk_en & bus_write_en & hit;

  interrupt_k_port_detect #(.WIDTH(4)) u_k0 (
    .clk(clk), .reset_n(reset_n), .clk_en_i(clk_en), .pins_i(k0_in),
    .enable_i(eik0_q), .compare_i(kcp0_q), .event_o(k0_event)
  );

  // Comparing against 1 means only a change to 0 counts: a falling edge.
  interrupt_k_port_detect #(.WIDTH(1)) u_k1 (
    .clk(clk), .reset_n(reset_n), .clk_en_i(clk_en), .pins_i(k1_in),
    .enable_i(eik1_q), .compare_i(1'b1), .event_o(k1_event)
  );

  always_comb begin
    it_d = it_q;     isw_d = isw_q;   ipt_d = ipt_q;     isio_d = isio_q;
    ik0_d = ik0_q;   ik1_d = ik1_q;   eit_d = eit_q;     eisw_d = eisw_q;
    eipt_d = eipt_q; eisio_d = eisio_q; eik0_d = eik0_q; eik1_d = eik1_q;
    kcp0_d = kcp0_q;
    if (rd_fire) begin
      case (off)
        OFF_IT:   it_d   = '0;
        OFF_ISW:  isw_d  = '0;
        OFF_IPT:  ipt_d  = 1'b0;
        OFF_ISIO: isio_d = 1'b0;
        OFF_IK0:  ik0_d  = 1'b0;
        OFF_IK1:  ik1_d  = 1'b0;
        default:  ;
      endcase
    end
    // New events are OR-ed after the clear so a same-cycle event survives the read.
    it_d   = it_d | clock_timer_event;
    isw_d  = isw_d | stopwatch_event;
    ipt_d  = ipt_d | prog_timer_event;
    isio_d = isio_d | serial_event;
    ik0_d  = ik0_d | k0_event;
    ik1_d  = ik1_d | k1_event;
    if (wr_fire) begin
      case (off)
        OFF_EIT:   eit_d   = bus_data_in;
        OFF_EISW:  eisw_d  = bus_data_in[1:0];
        OFF_EIPT:  eipt_d  = bus_data_in[0];
        OFF_EISIO: eisio_d = bus_data_in[0];
        OFF_EIK0:  eik0_d  = bus_data_in;
        OFF_EIK1:  eik1_d  = bus_data_in[0];
        OFF_KCP0:  kcp0_d  = bus_data_in;
        default:   ;
      endcase
    end
    // Built from next-state values so the request tracks flags/masks at the same edge.
    irq_d              = '0;
    irq_d[INT_IDX_CT]  = |(it_d & eit_d);
    irq_d[INT_IDX_SW]  = |(isw_d & eisw_d);
    irq_d[INT_IDX_PT]  = ipt_d & eipt_d;
    irq_d[INT_IDX_SIO] = isio_d & eisio_d;
    irq_d[INT_IDX_K0]  = ik0_d;
    irq_d[INT_IDX_K1]  = ik1_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      it_q <= '0;    isw_q <= '0;   ipt_q <= 1'b0;   isio_q <= 1'b0;
      ik0_q <= 1'b0; ik1_q <= 1'b0; eit_q <= '0;     eisw_q <= '0;
      eipt_q <= 1'b0; eisio_q <= 1'b0; eik0_q <= '0; eik1_q <= 1'b0;
      kcp0_q <= '0;  irq_q <= '0;
    end else if (clk_en) begin
      it_q <= it_d;     isw_q <= isw_d;   ipt_q <= ipt_d;     isio_q <= isio_d;
      ik0_q <= ik0_d;   ik1_q <= ik1_d;   eit_q <= eit_d;     eisw_q <= eisw_d;
      eipt_q <= eipt_d; eisio_q <= eisio_d; eik0_q <= eik0_d; eik1_q <= eik1_d;
      kcp0_q <= kcp0_d; irq_q <= irq_d;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus a randomized run, all
// checked against a register-map level reference model.
module tb_interrupt_controller;

  localparam logic [11:0] IO_BASE = 12'hF00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic [3:0]  clock_timer_event;
  logic [1:0]  stopwatch_event;
  logic        prog_timer_event;
  logic        serial_event;
  logic [3:0]  k0_in;
  logic        k1_in;
  logic [11:0] bus_addr;
  logic        bus_read_en;
  logic        bus_write_en;
  logic [3:0]  bus_data_in;
  logic [3:0]  bus_data_out;
  logic        bus_addr_hit;
  logic [14:0] interrupt_req;

  int compared = 0;
  int mismatched = 0;
  logic [14:0] exp_q[$];

  // Reference model state
  logic [3:0] m_it, m_eit, m_eik0, m_kcp0;
  logic [1:0] m_isw, m_eisw;
  logic       m_ipt, m_isio, m_ik0, m_ik1, m_eipt, m_eisio, m_eik1;
  logic [3:0] m_k0_d1, m_k0_d2, m_k0_prev;
  logic       m_k1_d1, m_k1_d2, m_k1_prev;

  interrupt_controller #(.IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .clock_timer_event(clock_timer_event), .stopwatch_event(stopwatch_event),
    .prog_timer_event(prog_timer_event), .serial_event(serial_event),
    .k0_in(k0_in), .k1_in(k1_in), .bus_addr(bus_addr),
    .bus_read_en(bus_read_en), .bus_write_en(bus_write_en),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_addr_hit(bus_addr_hit), .interrupt_req(interrupt_req)
  );

  always #5 clk = ~clk;

  function automatic logic m_hit(input logic [11:0] a);
    logic [11:0] o;
    o = a - IO_BASE;
    return (o <= 12'h005) || (o >= 12'h010 && o <= 12'h016);
  endfunction

  function automatic logic [3:0] m_read(input logic [11:0] a);
    logic [11:0] o;
    o = a - IO_BASE;
    case (o)
      12'h000: return m_it;
      12'h001: return {2'b00, m_isw};
      12'h002: return {3'b000, m_ipt};
      12'h003: return {3'b000, m_isio};
      12'h004: return {3'b000, m_ik0};
      12'h005: return {3'b000, m_ik1};
      12'h010: return m_eit;
      12'h011: return {2'b00, m_eisw};
      12'h012: return {3'b000, m_eipt};
      12'h013: return {3'b000, m_eisio};
      12'h014: return m_eik0;
      12'h015: return {3'b000, m_eik1};
      12'h016: return m_kcp0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [14:0] m_irq();
    return {8'h00, m_ipt & m_eipt, m_isio & m_eisio, m_ik0, m_ik1,
            |(m_isw & m_eisw), |(m_it & m_eit), 1'b0};
  endfunction

  // One clock edge: advance the model from the currently driven inputs, then wait for the edge.
  task automatic tick();
    logic [11:0] o;
    logic [3:0]  s0;
    logic        s1, k0ev, k1ev, h;
    o  = bus_addr - IO_BASE;
    h  = m_hit(bus_addr);
    s0 = m_k0_d2;
    s1 = m_k1_d2;
    if (!reset_n) begin
      m_it = '0; m_isw = '0; m_ipt = 0; m_isio = 0; m_ik0 = 0; m_ik1 = 0;
      m_eit = '0; m_eisw = '0; m_eipt = 0; m_eisio = 0; m_eik0 = '0; m_eik1 = 0;
      m_kcp0 = '0;
      m_k0_d1 = '1; m_k0_d2 = '1; m_k0_prev = '1;
      m_k1_d1 = 1;  m_k1_d2 = 1;  m_k1_prev = 1;
    end else begin
      if (clk_en) begin
        k0ev = 1'b0;
        for (int i = 0; i < 4; i++)
          if (m_eik0[i] && s0[i] != m_k0_prev[i] && s0[i] != m_kcp0[i]) k0ev = 1'b1;
        k1ev = m_eik1 && m_k1_prev == 1'b1 && s1 == 1'b0;
        if (bus_read_en && h) begin
          if (o == 12'h000) m_it = '0;
          if (o == 12'h001) m_isw = '0;
          if (o == 12'h002) m_ipt = 0;
          if (o == 12'h003) m_isio = 0;
          if (o == 12'h004) m_ik0 = 0;
          if (o == 12'h005) m_ik1 = 0;
        end
        m_it  = m_it | clock_timer_event;
        m_isw = m_isw | stopwatch_event;
        if (prog_timer_event) m_ipt = 1;
        if (serial_event) m_isio = 1;
        if (k0ev) m_ik0 = 1;
        if (k1ev) m_ik1 = 1;
        if (bus_write_en && h) begin
          if (o == 12'h010) m_eit = bus_data_in;
          if (o == 12'h011) m_eisw = bus_data_in[1:0];
          if (o == 12'h012) m_eipt = bus_data_in[0];
          if (o == 12'h013) m_eisio = bus_data_in[0];
          if (o == 12'h014) m_eik0 = bus_data_in;
          if (o == 12'h015) m_eik1 = bus_data_in[0];
          if (o == 12'h016) m_kcp0 = bus_data_in;
        end
        m_k0_prev = s0;
        m_k1_prev = s1;
      end
      m_k0_d2 = m_k0_d1; m_k0_d1 = k0_in;
      m_k1_d2 = m_k1_d1; m_k1_d1 = k1_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    clk_en = 1; clock_timer_event = '0; stopwatch_event = '0;
    prog_timer_event = 0; serial_event = 0;
    bus_read_en = 0; bus_write_en = 0; bus_data_in = '0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [3:0] d);
    bus_addr = a; bus_data_in = d; bus_write_en = 1;
    tick();
    bus_write_en = 0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [3:0] d);
    bus_addr = a; bus_read_en = 1;
    #2;
    d = bus_data_out;
    tick();
    bus_read_en = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); k0_in = 4'hF; k1_in = 1; bus_addr = IO_BASE;
    ticks(2);
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL reset_irq: got %h expected %h", interrupt_req, 15'h0000);
    end
    compared++;
    if (bus_data_out !== 4'h0 || bus_addr_hit !== 1'b1) begin
      mismatched++; $display("FAIL reset_read: got %h/%b expected 0/1", bus_data_out, bus_addr_hit);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_clock_timer();
    logic [3:0] d;
    do_write(IO_BASE + 12'h010, 4'h1);
    clock_timer_event = 4'b0001;
    tick();
    clock_timer_event = '0;
    compared++;
    if (interrupt_req !== 15'h0002) begin
      mismatched++; $display("FAIL ct_irq: got %h expected %h", interrupt_req, 15'h0002);
    end
    do_read(IO_BASE, d);
    compared++;
    if (d !== 4'h1) begin
      mismatched++; $display("FAIL ct_read: got %h expected %h", d, 4'h1);
    end
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL ct_clear: got %h expected %h", interrupt_req, 15'h0000);
    end
    do_read(IO_BASE, d);
    compared++;
    if (d !== 4'h0) begin
      mismatched++; $display("FAIL ct_reread: got %h expected %h", d, 4'h0);
    end
  endtask

  task automatic test_mask_late();
    logic [3:0] d;
    prog_timer_event = 1;
    tick();
    prog_timer_event = 0;
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL pt_masked: got %h expected %h", interrupt_req, 15'h0000);
    end
    do_write(IO_BASE + 12'h012, 4'h1);
    compared++;
    if (interrupt_req !== 15'h0040) begin
      mismatched++; $display("FAIL pt_unmask: got %h expected %h", interrupt_req, 15'h0040);
    end
    do_write(IO_BASE + 12'h012, 4'h0);
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL pt_remask: got %h expected %h", interrupt_req, 15'h0000);
    end
    do_read(IO_BASE + 12'h002, d);
    compared++;
    if (d !== 4'h1) begin
      mismatched++; $display("FAIL pt_flag_kept: got %h expected %h", d, 4'h1);
    end
  endtask

  task automatic test_read_set_race();
    logic [3:0] d;
    do_write(IO_BASE + 12'h011, 4'hF);
    stopwatch_event = 2'b01;
    tick();
    stopwatch_event = 2'b10;
    do_read(IO_BASE + 12'h001, d);
    stopwatch_event = 2'b00;
    compared++;
    if (d !== 4'h1) begin
      mismatched++; $display("FAIL sw_race_read: got %h expected %h", d, 4'h1);
    end
    compared++;
    if (interrupt_req !== 15'h0004) begin
      mismatched++; $display("FAIL sw_race_irq: got %h expected %h", interrupt_req, 15'h0004);
    end
    do_read(IO_BASE + 12'h001, d);
    compared++;
    if (d !== 4'h2) begin
      mismatched++; $display("FAIL sw_race_after: got %h expected %h", d, 4'h2);
    end
  endtask

  task automatic test_k0();
    logic [3:0] d;
    do_write(IO_BASE + 12'h016, 4'h0);
    do_write(IO_BASE + 12'h014, 4'b0100);
    k0_in = 4'b1011;
    ticks(4);
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL k0_match_kcp: got %h expected %h", interrupt_req, 15'h0000);
    end
    k0_in = 4'b1111;
    ticks(2);
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL k0_sync_early: got %h expected %h", interrupt_req, 15'h0000);
    end
    tick();
    compared++;
    if (interrupt_req !== 15'h0010) begin
      mismatched++; $display("FAIL k0_event: got %h expected %h", interrupt_req, 15'h0010);
    end
    do_read(IO_BASE + 12'h004, d);
    k0_in = 4'b1101;
    ticks(4);
    k0_in = 4'b1111;
    ticks(4);
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL k0_disabled_pin: got %h expected %h", interrupt_req, 15'h0000);
    end
  endtask

  task automatic test_k1_and_reset();
    logic [3:0] d;
    do_write(IO_BASE + 12'h015, 4'h1);
    k1_in = 0;
    ticks(3);
    compared++;
    if (interrupt_req !== 15'h0008) begin
      mismatched++; $display("FAIL k1_fall: got %h expected %h", interrupt_req, 15'h0008);
    end
    do_read(IO_BASE + 12'h005, d);
    k1_in = 1;
    ticks(4);
    compared++;
    if (interrupt_req !== 15'h0000) begin
      mismatched++; $display("FAIL k1_rise: got %h expected %h", interrupt_req, 15'h0000);
    end
    k1_in = 0;
    do_write(IO_BASE + 12'h010, 4'hF);
    clock_timer_event = 4'b1000;
    ticks(3);
    clock_timer_event = '0;
    compared++;
    if (interrupt_req !== 15'h000A) begin
      mismatched++; $display("FAIL k1_pending: got %h expected %h", interrupt_req, 15'h000A);
    end
    reset_n = 0;
    bus_addr = IO_BASE + 12'h010;
    tick();
    #2;
    compared++;
    if (interrupt_req !== 15'h0000 || bus_data_out !== 4'h0) begin
      mismatched++; $display("FAIL mid_reset: got %h/%h expected 0/0", interrupt_req, bus_data_out);
    end
    k1_in = 1;
    reset_n = 1;
    ticks(3);
  endtask

  task automatic test_unmapped();
    logic [3:0] d;
    do_write(IO_BASE + 12'h010, 4'h5);
    do_write(IO_BASE + 12'h002, 4'hF);
    do_write(IO_BASE + 12'h020, 4'hF);
    do_write(IO_BASE + 12'h011, 4'hF);
    bus_addr = IO_BASE + 12'h020;
    #2;
    compared++;
    if (bus_addr_hit !== 1'b0 || bus_data_out !== 4'h0) begin
      mismatched++; $display("FAIL unmapped_hit: got %b/%h expected 0/0", bus_addr_hit, bus_data_out);
    end
    do_read(IO_BASE + 12'h002, d);
    compared++;
    if (d !== 4'h0) begin
      mismatched++; $display("FAIL factor_write: got %h expected %h", d, 4'h0);
    end
    do_read(IO_BASE + 12'h010, d);
    compared++;
    if (d !== 4'h5) begin
      mismatched++; $display("FAIL eit_kept: got %h expected %h", d, 4'h5);
    end
    do_read(IO_BASE + 12'h011, d);
    compared++;
    if (d !== 4'h3) begin
      mismatched++; $display("FAIL eisw_width: got %h expected %h", d, 4'h3);
    end
  endtask

  task automatic test_clk_en_low();
    logic [3:0] d;
    clk_en = 0;
    clock_timer_event = 4'hF; serial_event = 1;
    do_write(IO_BASE + 12'h010, 4'hA);
    idle();
    do_read(IO_BASE + 12'h010, d);
    compared++;
    if (d !== 4'h5) begin
      mismatched++; $display("FAIL clk_en_write: got %h expected %h", d, 4'h5);
    end
    do_read(IO_BASE, d);
    compared++;
    if (d !== 4'h0) begin
      mismatched++; $display("FAIL clk_en_event: got %h expected %h", d, 4'h0);
    end
  endtask

  task automatic test_random();
    logic [14:0] e;
    logic [11:0] a;
    for (int n = 0; n < 600; n++) begin
      clk_en            = ($urandom_range(0, 3) != 0);
      reset_n           = ($urandom_range(0, 199) != 0);
      clock_timer_event = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      stopwatch_event   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'h0;
      prog_timer_event  = ($urandom_range(0, 7) == 0);
      serial_event      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) k0_in[$urandom_range(0, 3)] = ~k0_in[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) k1_in = ~k1_in;
      a = ($urandom_range(0, 15) == 0) ? 12'h123 : IO_BASE + 12'($urandom_range(0, 24));
      bus_addr     = a;
      bus_read_en  = ($urandom_range(0, 2) == 0);
      bus_write_en = ($urandom_range(0, 3) == 0);
      bus_data_in  = 4'($urandom_range(0, 15));
      #2;
      compared++;
      if (bus_data_out !== m_read(a) || bus_addr_hit !== m_hit(a)) begin
        mismatched++;
        $display("FAIL rnd_bus[%0d]: addr %h got %h/%b expected %h/%b", n, a,
                 bus_data_out, bus_addr_hit, m_read(a), m_hit(a));
      end
      tick();
      exp_q.push_back(m_irq());
      e = exp_q.pop_front();
      compared++;
      if (interrupt_req !== e) begin
        mismatched++; $display("FAIL rnd_irq[%0d]: got %h expected %h", n, interrupt_req, e);
      end
    end
    reset_n = 1;
    idle();
  endtask

  initial begin
    test_reset();
    test_clock_timer();
    test_mask_late();
    test_read_set_race();
    test_k0();
    test_k1_and_reset();
    test_unmapped();
    test_clk_en_low();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
